// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register bank, oversampled in the clk domain.
// Define SPI_READBACK_EN to enable read-back of registers on cipo.
module spi_reg_bank #(
   parameter int NUM_REGS = 5,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       cs_n,
   input  logic                       copi,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic sclk_p0, sclk_p1, sclk_p2;
   logic cs_p0, cs_p1, cs_p2;
   logic copi_p0, copi_p1, copi_p2;

   // p0/p1 form the synchronizer, p2 is the history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_p0   <= 1'b1;
         cs_p1   <= 1'b1;
         cs_p2   <= 1'b1;
         copi_p0 <= 1'b0;
         copi_p1 <= 1'b0;
         copi_p2 <= 1'b0;
      end else begin
         sclk_p0 <= sclk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_p0   <= cs_n;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
         copi_p0 <= copi;
         copi_p1 <= copi_p0;
         copi_p2 <= copi_p1;
      end
   end

   logic sclk_rise, cs_fall, cs_rise;
   assign sclk_rise = sclk_p1 & ~sclk_p2;
   assign cs_fall   = ~cs_p1 & cs_p2;
   assign cs_rise   = cs_p1 & ~cs_p2;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [FRAME_LEN-1:0] sr;
   logic [FRAME_LEN-1:0] sr_nxt;
   logic                 fall_pend;
   logic [DATA_W-1:0]    mem [NUM_REGS];
   logic [ADDR_W-1:0]    c_addr;
   logic [DATA_W-1:0]    c_data;

   // copi_p2 is one cycle older than the sclk sample, giving extra setup margin
   assign sr_nxt = {sr[FRAME_LEN-2:0], copi_p2};
   assign c_addr = sr[DATA_W +: ADDR_W];
   assign c_data = sr[DATA_W-1:0];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g*DATA_W +: DATA_W] = mem[g];
   end

`ifdef SPI_READBACK_EN
   logic              sclk_fall;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] so_reg;
   logic              oe_q;

   assign sclk_fall = ~sclk_p1 & sclk_p2;
   assign rd_addr   = sr_nxt[ADDR_W-1:0];
   assign cipo      = so_reg[DATA_W-1];
   assign cipo_oe   = oe_q;

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rd_addr == ADDR_W'(k)) rd_data = mem[k];
      end
   end
`else
   assign cipo    = 1'b0;
   assign cipo_oe = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         fall_pend <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
`ifdef SPI_READBACK_EN
         so_reg    <= '0;
         oe_q      <= 1'b0;
`endif
      end else begin
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               fall_pend <= 1'b0;
               if (cs_fall || fall_pend) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  sr    <= '0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state <= COMMIT;
               end else if (sclk_rise) begin
                  sr  <= sr_nxt;
                  cnt <= sat_inc(cnt);
               end
`ifdef SPI_READBACK_EN
               // the rise carrying the last address bit of a read frame loads the data
               if (cs_rise) begin
                  so_reg <= '0;
                  oe_q   <= 1'b0;
               end else if (sclk_rise && cnt == CNT_ADDR && !sr_nxt[ADDR_W]) begin
                  so_reg <= rd_data;
                  oe_q   <= 1'b1;
               end else if (sclk_fall && oe_q) begin
                  so_reg <= so_reg << 1;
               end
`endif
            end
            COMMIT: begin
               state     <= IDLE;
               fall_pend <= cs_fall;
               if (cnt != CNT_FULL) begin
                  frame_err <= 1'b1;
               end else if (sr[FRAME_LEN-1]) begin
                  if (32'(c_addr) < NUM_REGS) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (c_addr == ADDR_W'(k)) mem[k] <= c_data;
                     end
                     wr_strobe <= 1'b1;
                     wr_addr   <= c_addr;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
